// File: rtl/ppu_pkg.sv
// Shared PPU constants: register addresses, PPUSTATUS bit positions and
// the width of the post-read suppression counter.
package ppu_pkg;

  localparam logic [2:0] ADDR_PPUCTRL   = 3'd0;
  localparam logic [2:0] ADDR_PPUSTATUS = 3'd2;

  localparam int STAT_VBLANK_BIT = 7;
  localparam int STAT_SPR0_BIT   = 6;
  localparam int STAT_OVF_BIT    = 5;

  localparam int SUPP_CNT_W = 3;

endpackage

// File: rtl/ppu_suppress_timer.sv
// Counts down ce ticks after a PPUSTATUS read; while non-zero, an arriving
// vblank start is treated as raced by the CPU and is dropped.
module ppu_suppress_timer
  import ppu_pkg::*;
#(
  parameter int unsigned SUPPRESS_WINDOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  ce,
  output logic [SUPP_CNT_W-1:0] count,
  output logic                  active
);

  logic [SUPP_CNT_W-1:0] r_cnt;

  // A reload wins over the decrement of the same clk, so the read's own tick
  // never counts toward the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= SUPP_CNT_W'(SUPPRESS_WINDOW);
    end else if (ce && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign count  = r_cnt;
  assign active = (r_cnt != '0);

endmodule

// File: rtl/ppu_status_nmi.sv
// PPUSTATUS flags (vblank, sprite-0 hit, overflow), open-bus latch and the
// registered NMI request, including the read-vs-vblank race suppression.
module ppu_status_nmi
  import ppu_pkg::*;
#(
  parameter int unsigned SUPPRESS_WINDOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       entering_vblank,
  input  logic       exiting_vblank,
  input  logic       set_sprite0_hit,
  input  logic       set_overflow,
  input  logic       cpu_read,
  input  logic       cpu_write,
  input  logic [2:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] status_dout,
  output logic       vblank_flag,
  output logic       nmi
);

  logic       r_vblank, r_spr0, r_ovf, r_nmi_en, r_block, r_nmi;
  logic [7:0] r_open_bus;

  logic       w_vblank_nx, w_spr0_nx, w_ovf_nx, w_nmi_en_nx, w_block_nx;
  logic [7:0] w_open_bus_nx;
  logic       w_status_rd, w_supp_active;
  logic [SUPP_CNT_W-1:0] w_supp_cnt;
  logic       w_unused;

  assign w_status_rd = cpu_read && (cpu_addr == ADDR_PPUSTATUS);

  ppu_suppress_timer #(
    .SUPPRESS_WINDOW(SUPPRESS_WINDOW)
  ) u_suppress (
    .clk   (clk),
    .reset (reset),
    .load  (w_status_rd),
    .ce    (ce),
    .count (w_supp_cnt),
    .active(w_supp_active)
  );

  always_comb begin
    w_vblank_nx   = r_vblank;
    w_spr0_nx     = r_spr0;
    w_ovf_nx      = r_ovf;
    w_block_nx    = r_block;
    w_nmi_en_nx   = r_nmi_en;
    w_open_bus_nx = r_open_bus;

    if (ce && exiting_vblank) begin
      w_vblank_nx = 1'b0;
      w_spr0_nx   = 1'b0;
      w_ovf_nx    = 1'b0;
      w_block_nx  = 1'b0;
    end else begin
      // A read racing the vblank start (same clk or within the window)
      // drops the flag and locks NMI out for the rest of the frame.
      if (ce && entering_vblank) begin
        if (w_status_rd || w_supp_active) begin
          w_block_nx = 1'b1;
        end else begin
          w_vblank_nx = 1'b1;
        end
      end
      if (ce && set_sprite0_hit) w_spr0_nx = 1'b1;
      if (ce && set_overflow)    w_ovf_nx  = 1'b1;
    end

    if (w_status_rd) w_vblank_nx = 1'b0;

    if (cpu_write) begin
      w_open_bus_nx = cpu_din;
      if (cpu_addr == ADDR_PPUCTRL) w_nmi_en_nx = cpu_din[7];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vblank   <= 1'b0;
      r_spr0     <= 1'b0;
      r_ovf      <= 1'b0;
      r_block    <= 1'b0;
      r_nmi_en   <= 1'b0;
      r_open_bus <= '0;
      r_nmi      <= 1'b0;
    end else begin
      r_vblank   <= w_vblank_nx;
      r_spr0     <= w_spr0_nx;
      r_ovf      <= w_ovf_nx;
      r_block    <= w_block_nx;
      r_nmi_en   <= w_nmi_en_nx;
      r_open_bus <= w_open_bus_nx;
      r_nmi      <= w_nmi_en_nx && w_vblank_nx && !w_block_nx;
    end
  end

  always_comb begin
    status_dout                  = {3'b000, r_open_bus[4:0]};
    status_dout[STAT_VBLANK_BIT] = r_vblank;
    status_dout[STAT_SPR0_BIT]   = r_spr0;
    status_dout[STAT_OVF_BIT]    = r_ovf;
  end

  assign vblank_flag = r_vblank;
  assign nmi         = r_nmi;

  // Upper open-bus bits are not visible through PPUSTATUS.
  assign w_unused = ^{r_open_bus[7:5], w_supp_cnt};

endmodule

// File: doc/ppu_status_nmi.md
PPU_STATUS_NMI -- requirements
Module: ppu_status_nmi

Interface
REQ-001 SHALL have parameter SUPPRESS_WINDOW, default 1, meaning the number of ce ticks before entering_vblank within which a status read cancels that frame's flag set and NMI (range 0..7).
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ce, input, 1, PPU dot enable (one pulse per PPU cycle).
REQ-005 SHALL have port entering_vblank, input, 1, end-of-line pulse for scanline 240 from the scanline/cycle counter stage.
REQ-006 SHALL have port exiting_vblank, input, 1, end-of-line pulse for scanline 260 from the same stage.
REQ-007 SHALL have port set_sprite0_hit, input, 1, sprite-0 hit event from the sprite unit, qualified by ce.
REQ-008 SHALL have port set_overflow, input, 1, sprite-overflow event, qualified by ce.
REQ-009 SHALL have port cpu_read, input, 1, single-clk CPU register read strobe, not qualified by ce.
REQ-010 SHALL have port cpu_write, input, 1, single-clk CPU register write strobe, not qualified by ce.
REQ-011 SHALL have port cpu_addr, input, 3, PPU register select.
REQ-012 SHALL have port cpu_din, input, 8, CPU write data.
REQ-013 SHALL have port status_dout, output, 8, PPUSTATUS read value.
REQ-014 SHALL have port vblank_flag, output, 1, current PPUSTATUS bit 7.
REQ-015 SHALL have port nmi, output, 1, registered active-high NMI request to the CPU.

Function
REQ-016 status_dout SHALL be combinational: {vblank_flag, sprite0_hit, overflow, open_bus[4:0]}, reflecting state before any same-clk update.
REQ-017 open_bus[7:0] SHALL load cpu_din on every cpu_write, any address.
REQ-018 nmi_enable SHALL load cpu_din[7] on cpu_write with cpu_addr==0; other bits ignored.
REQ-019 A status read (cpu_read, cpu_addr==2) SHALL clear vblank_flag on the next clk edge; sprite0_hit/overflow are unaffected.
REQ-020 A status read SHALL load suppress_cnt with SUPPRESS_WINDOW; each ce tick with suppress_cnt!=0 SHALL decrement it by 1, saturating at 0.
REQ-021 On ce && entering_vblank, vblank_flag SHALL be set unless a status read occurs the same clk or suppress_cnt!=0; otherwise the set is dropped and frame_nmi_block SHALL be set.
REQ-022 On ce && exiting_vblank, vblank_flag, sprite0_hit, overflow and frame_nmi_block SHALL clear, taking priority over set pulses the same clk.
REQ-023 sprite0_hit/overflow SHALL set on ce && their event input and hold until exiting_vblank or reset.
REQ-024 nmi SHALL be registered: next value = nmi_enable_next && vblank_flag_next && !frame_nmi_block_next.
REQ-025 Writing nmi_enable 0->1 while vblank_flag=1 SHALL assert nmi on the following clk; 1->0 SHALL deassert it on the following clk.
REQ-026 Simultaneous status read and cpu_write in one clk SHALL both take effect.
REQ-027 entering_vblank/exiting_vblank with ce=0 SHALL be ignored.

Reset
REQ-028 On reset: vblank_flag=0, sprite0_hit=0, overflow=0, nmi_enable=0, open_bus=0, suppress_cnt=0, frame_nmi_block=0, nmi=0; reset SHALL override all same-clk events.
REQ-029 Reset mid-vblank SHALL leave nmi low until a new entering_vblank with nmi_enable=1.

Structure
REQ-030 Register addresses (PPUCTRL=0, PPUSTATUS=2) and status bit positions (7,6,5) SHALL be constants in the shared ppu_pkg package.
REQ-031 The suppression counter SHALL be a sub-module ppu_suppress_timer (load, ce, count, active output); all other logic SHALL be flat.

Verification
REQ-032 nmi_enable=1, entering_vblank with ce -> vblank_flag=1 and nmi=1 one clk later; exiting_vblank -> both 0 one clk later.
REQ-033 Status read same clk as entering_vblank -> status_dout[7]=0, vblank_flag stays 0, nmi stays 0 for the whole frame.
REQ-034 SUPPRESS_WINDOW=1, status read 1 ce tick before entering_vblank -> flag suppressed; read 2 ticks before -> flag sets to 1.
REQ-035 Write 0x80 to addr 0 mid-vblank (flag=1) -> nmi=1 next clk; write 0x00 -> nmi=0 next clk; write 0x1F anywhere then read status -> status_dout[4:0]=5'h1F.
REQ-036 set_sprite0_hit and set_overflow pulsed, then status read -> status_dout[6:5]=2'b11, vblank cleared, bits 6:5 persist until exiting_vblank.
REQ-037 Assert reset during vblank with nmi=1 -> all outputs 0 next clk, status_dout=8'h00.
